// File: rtl/hist_scan_ctrl.sv
// hist_scan_ctrl
// Drains the per-pixel histogram RAM into the peak detector one pixel at a
// time and collects the winning bin of every pixel. Passes alternate
// between coarse histogram (his_num=0) and fine histogram (his_num=1).
//
// Ports
//   i_clk, i_reset          clock, synchronous active-low reset
//   i_acq_count_finish      start request, only honoured while idle
//   o_ram_rd_en, o_ram_addr histogram RAM read strobe and {pixel, bin} address
//   i_ram_rd_data           RAM data, valid one cycle after o_ram_rd_en
//   o_det_clr               restarts max tracking in the detector
//   o_det_valid/noc/addr    sample stream into the detector
//   i_det_peak              detector's current argmax bin
//   o_his_num               pass type, 0 = CH, 1 = FH
//   o_result_*              per-pixel result (valid pulse, pixel, bin, empty)
//   o_busy, o_pass_done     activity flag and end-of-pass pulse
module hist_scan_ctrl #(
  parameter int NB     = 6,
  parameter int PEAK_W = 21,
  parameter int PIXELS = 8,
  parameter int PIX_W  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_acq_count_finish,
  output logic                  o_ram_rd_en,
  output logic [PIX_W+NB-1:0]   o_ram_addr,
  input  logic [PEAK_W-1:0]     i_ram_rd_data,
  output logic                  o_det_clr,
  output logic                  o_det_valid,
  output logic [PEAK_W-1:0]     o_det_noc,
  output logic [NB-1:0]         o_det_addr,
  input  logic [NB-1:0]         i_det_peak,
  output logic                  o_his_num,
  output logic                  o_result_valid,
  output logic [PIX_W-1:0]      o_result_pix,
  output logic [NB-1:0]         o_result_bin,
  output logic                  o_result_empty,
  output logic                  o_busy,
  output logic                  o_pass_done
);

  localparam logic [NB:0]      LAST_BIN = {1'b0, {NB{1'b1}}};
  localparam logic [NB:0]      BIN_ONE  = (NB+1)'(1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SCAN,
    S_DRAIN,
    S_LATCH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [PIX_W-1:0] r_pixCnt;
  logic [NB:0]      r_binCnt;
  logic             r_drainCnt;
  logic             r_nonZero;
  logic             r_hisNum;
  logic             r_detValid;
  logic [NB-1:0]    r_detAddr;
  logic [PIX_W-1:0] r_resultPix;
  logic [NB-1:0]    r_resultBin;
  logic             r_resultEmpty;
  logic             w_lastBin;
  logic             w_lastPix;
  logic             w_drainDone;

  assign w_lastBin   = (r_binCnt == LAST_BIN);
  assign w_lastPix   = (r_pixCnt == LAST_PIX);
  assign w_drainDone = r_drainCnt;

  // State register; everything else in the block is steered by it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the single-cycle strobes, which are all pure
  // functions of the current state so they vanish the cycle after a reset.
  always_comb begin
    w_nextState    = r_state;
    o_ram_rd_en    = 1'b0;
    o_det_clr      = 1'b0;
    o_result_valid = 1'b0;
    o_pass_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_acq_count_finish) w_nextState = S_CLR;
      end
      S_CLR: begin
        o_det_clr   = 1'b1;
        w_nextState = S_SCAN;
      end
      S_SCAN: begin
        o_ram_rd_en = 1'b1;
        if (w_lastBin) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drainDone) w_nextState = S_LATCH;
      end
      S_LATCH: begin
        o_result_valid = 1'b1;
        w_nextState    = w_lastPix ? S_DONE : S_CLR;
      end
      S_DONE: begin
        o_pass_done = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Address is forced to zero outside SCAN so the RAM port is quiet when
  // nothing is being read.
  assign o_ram_addr = o_ram_rd_en ? {r_pixCnt, r_binCnt[NB-1:0]} : '0;
  assign o_busy     = (r_state != S_IDLE);
  assign o_his_num  = r_hisNum;

  // Pixel, bin and drain counters. The bin counter carries one extra bit so
  // the end-of-scan compare never relies on the address wrapping to zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pixCnt   <= '0;
      r_binCnt   <= '0;
      r_drainCnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_acq_count_finish) r_pixCnt <= '0;
        end
        S_CLR: begin
          r_binCnt <= '0;
        end
        S_SCAN: begin
          r_binCnt   <= r_binCnt + BIN_ONE;
          r_drainCnt <= 1'b0;
        end
        S_DRAIN: begin
          r_drainCnt <= 1'b1;
        end
        S_LATCH: begin
          if (!w_lastPix) r_pixCnt <= r_pixCnt + PIX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Detector feed. The RAM already returns data one cycle after the read
  // strobe, so only the strobe and the bin index need a register stage to
  // line up with it. The data is masked while no sample is valid so the
  // detector never sees stale RAM output.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_detValid <= 1'b0;
      r_detAddr  <= '0;
    end else begin
      r_detValid <= o_ram_rd_en;
      r_detAddr  <= o_ram_rd_en ? r_binCnt[NB-1:0] : '0;
    end
  end

  assign o_det_valid = r_detValid;
  assign o_det_addr  = r_detAddr;
  assign o_det_noc   = r_detValid ? i_ram_rd_data : '0;

  // Tracks whether any sample of the current pixel was nonzero; restarted
  // together with the detector.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_nonZero <= 1'b0;
    end else if (r_state == S_CLR) begin
      r_nonZero <= 1'b0;
    end else if (r_detValid && (o_det_noc != '0)) begin
      r_nonZero <= 1'b1;
    end
  end

  // Result capture happens on the edge that enters LATCH, at which point the
  // detector has already registered the last sample. The values are thus on
  // the outputs during the LATCH cycle alongside o_result_valid, and hold
  // until the next pixel is captured.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_resultPix   <= '0;
      r_resultBin   <= '0;
      r_resultEmpty <= 1'b0;
    end else if ((r_state == S_DRAIN) && w_drainDone) begin
      r_resultPix   <= r_pixCnt;
      r_resultBin   <= i_det_peak;
      r_resultEmpty <= ~r_nonZero;
    end
  end

  assign o_result_pix   = r_resultPix;
  assign o_result_bin   = r_resultBin;
  assign o_result_empty = r_resultEmpty;

  // Pass type flips at the end of every completed pass; an aborted pass
  // leaves it at its reset value of CH.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hisNum <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_hisNum <= ~r_hisNum;
    end
  end

endmodule

// File: tb/tb_hist_scan_ctrl.sv
module tb_hist_scan_ctrl;

  localparam int NB       = 6;
  localparam int PEAK_W   = 21;
  localparam int PIXELS   = 8;
  localparam int PIX_W    = 3;
  localparam int BINS     = 64;
  localparam int PERIOD   = 68;
  localparam int DONE_CYC = 545;
  localparam int RUN_CYC  = 700;

  logic                clk = 1'b0;
  logic                reset;
  logic                acq;
  logic                ram_rd_en;
  logic [PIX_W+NB-1:0] ram_addr;
  logic [PEAK_W-1:0]   ram_rd_data;
  logic                det_clr;
  logic                det_valid;
  logic [PEAK_W-1:0]   det_noc;
  logic [NB-1:0]       det_addr;
  logic [NB-1:0]       det_peak;
  logic                his_num;
  logic                result_valid;
  logic [PIX_W-1:0]    result_pix;
  logic [NB-1:0]       result_bin;
  logic                result_empty;
  logic                busy;
  logic                pass_done;
  logic [52:0]         allOuts;

  int checks = 0;
  int errors = 0;

  // Histogram contents and the observations gathered during one pass
  logic [PEAK_W-1:0] mem [PIXELS*BINS];
  logic [PEAK_W-1:0] detMax;
  int                obsN;
  int                obsCyc [16];
  logic [PIX_W-1:0]  obsPix [16];
  logic [NB-1:0]     obsBin [16];
  logic              obsEmpty [16];
  int                obsDoneN;
  int                obsDoneCyc;
  int                obsBusyFall;
  int                obsBusyBad;
  int                obsHisBad;
  int                obsAddrBad;
  logic              obsHisAfter;

  always #5 clk = ~clk;

  hist_scan_ctrl #(.NB(NB), .PEAK_W(PEAK_W), .PIXELS(PIXELS), .PIX_W(PIX_W)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_acq_count_finish (acq),
    .o_ram_rd_en        (ram_rd_en),
    .o_ram_addr         (ram_addr),
    .i_ram_rd_data      (ram_rd_data),
    .o_det_clr          (det_clr),
    .o_det_valid        (det_valid),
    .o_det_noc          (det_noc),
    .o_det_addr         (det_addr),
    .i_det_peak         (det_peak),
    .o_his_num          (his_num),
    .o_result_valid     (result_valid),
    .o_result_pix       (result_pix),
    .o_result_bin       (result_bin),
    .o_result_empty     (result_empty),
    .o_busy             (busy),
    .o_pass_done        (pass_done)
  );

  assign allOuts = {ram_rd_en, ram_addr, det_clr, det_valid, det_noc, det_addr, his_num,
                    result_valid, result_pix, result_bin, result_empty, busy, pass_done};

  // Histogram RAM: one-cycle read latency, garbage on the bus when not read
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
    else           ram_rd_data <= PEAK_W'($urandom);
  end

  // Peak detector stand-in: strict greater-than keeps the first maximum
  always @(posedge clk) begin
    if (!reset || det_clr) begin
      detMax   <= '0;
      det_peak <= '0;
    end else if (det_valid && (det_noc > detMax)) begin
      detMax   <= det_noc;
      det_peak <= det_addr;
    end
  end

  // Reference: first bin holding the largest count; empty when all are zero
  task automatic refPixel(input int p, output logic [NB-1:0] bin, output logic empty);
    logic [PEAK_W-1:0] best;
    best = '0;
    bin  = '0;
    for (int b = 0; b < BINS; b++) begin
      if (mem[p*BINS+b] > best) begin
        best = mem[p*BINS+b];
        bin  = NB'(b);
      end
    end
    empty = (best == '0);
  endtask

  task automatic fillPattern();
    for (int p = 0; p < PIXELS; p++)
      for (int b = 0; b < BINS; b++)
        mem[p*BINS+b] = (b == 5*p+3) ? PEAK_W'(100+p) : PEAK_W'(1);
  endtask

  task automatic fillRandom(input int zeroPix);
    for (int p = 0; p < PIXELS; p++)
      for (int b = 0; b < BINS; b++)
        mem[p*BINS+b] = (p == zeroPix) ? '0 : PEAK_W'($urandom_range(0, 40));
  endtask

  // Issues a start pulse and records what the DUT does for nCycles cycles.
  // Cycle 1 is the first cycle after the edge that samples the start.
  task automatic applyStimulus(input int nCycles, input bit pulseStarts, input logic expHis);
    int            p;
    int            off;
    logic          expRd;
    logic [PIX_W+NB-1:0] expAddr;
    obsN = 0; obsDoneN = 0; obsDoneCyc = -1; obsBusyFall = -1;
    obsBusyBad = 0; obsHisBad = 0; obsAddrBad = 0; obsHisAfter = 1'bx;
    for (int k = 0; k < 16; k++) begin
      obsCyc[k] = -1; obsPix[k] = 'x; obsBin[k] = 'x; obsEmpty[k] = 1'bx;
    end
    @(negedge clk);
    acq = 1'b1;
    @(posedge clk);
    #1;
    acq = 1'b0;
    for (int cyc = 1; cyc <= nCycles; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      p       = (cyc - 1) / PERIOD;
      off     = (cyc - 1) % PERIOD;
      expRd   = (cyc <= PIXELS*PERIOD) && (off >= 1) && (off <= BINS);
      expAddr = expRd ? (PIX_W+NB)'(p*BINS + off - 1) : '0;
      if ((ram_rd_en !== expRd) || (ram_addr !== expAddr)) obsAddrBad++;
      if (result_valid === 1'b1) begin
        if (obsN < 16) begin
          obsCyc[obsN]   = cyc;
          obsPix[obsN]   = result_pix;
          obsBin[obsN]   = result_bin;
          obsEmpty[obsN] = result_empty;
        end
        obsN++;
      end
      if (pass_done === 1'b1) begin
        obsDoneN++;
        obsDoneCyc = cyc;
      end
      if (busy !== (cyc <= DONE_CYC)) obsBusyBad++;
      if ((busy !== 1'b1) && (obsBusyFall < 0)) obsBusyFall = cyc;
      if ((cyc <= DONE_CYC) && (his_num !== expHis)) obsHisBad++;
      obsHisAfter = his_num;
      acq = pulseStarts && ((cyc == 100) || (cyc == 300));
    end
    acq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    acq   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (allOuts !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle_outputs cycle %0d: got %h expected 0", c, allOuts);
      end
    end
  endtask

  task automatic test_ch_pass();
    logic [NB-1:0] eb;
    logic          ee;
    fillPattern();
    applyStimulus(RUN_CYC, 1'b0, 1'b0);
    checks++;
    if (obsN !== PIXELS) begin
      errors++; $display("[TB] FAIL ch_result_count: got %0d expected %0d", obsN, PIXELS);
    end
    for (int k = 0; k < PIXELS; k++) begin
      refPixel(k, eb, ee);
      checks++;
      if (obsCyc[k] !== PERIOD*(k+1)) begin
        errors++; $display("[TB] FAIL ch_result_cycle[%0d]: got %0d expected %0d", k, obsCyc[k], PERIOD*(k+1));
      end
      checks++;
      if (obsPix[k] !== 3'(k)) begin
        errors++; $display("[TB] FAIL ch_result_pix[%0d]: got %0d expected %0d", k, obsPix[k], k);
      end
      checks++;
      if ((obsBin[k] !== eb) || (eb !== NB'(5*k+3))) begin
        errors++; $display("[TB] FAIL ch_result_bin[%0d]: got %0d expected %0d", k, obsBin[k], 5*k+3);
      end
      checks++;
      if (obsEmpty[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL ch_result_empty[%0d]: got %b expected 0", k, obsEmpty[k]);
      end
    end
    checks++;
    if ((obsDoneN !== 1) || (obsDoneCyc !== DONE_CYC)) begin
      errors++; $display("[TB] FAIL ch_pass_done: got %0d pulses at %0d expected 1 at %0d", obsDoneN, obsDoneCyc, DONE_CYC);
    end
    checks++;
    if ((obsBusyFall !== DONE_CYC+1) || (obsBusyBad !== 0)) begin
      errors++; $display("[TB] FAIL ch_busy: fall at %0d with %0d bad cycles expected fall at %0d", obsBusyFall, obsBusyBad, DONE_CYC+1);
    end
    checks++;
    if (obsAddrBad !== 0) begin
      errors++; $display("[TB] FAIL ch_ram_reads: got %0d bad cycles expected 0", obsAddrBad);
    end
    checks++;
    if ((obsHisBad !== 0) || (obsHisAfter !== 1'b1)) begin
      errors++; $display("[TB] FAIL ch_his_num: got %0d bad cycles and final %b expected 0 and 1", obsHisBad, obsHisAfter);
    end
  endtask

  task automatic test_alternation_zero_pixel();
    logic [NB-1:0] eb;
    logic          ee;
    fillRandom(2);
    applyStimulus(RUN_CYC, 1'b0, 1'b1);
    checks++;
    if (obsN !== PIXELS) begin
      errors++; $display("[TB] FAIL fh_result_count: got %0d expected %0d", obsN, PIXELS);
    end
    for (int k = 0; k < PIXELS; k++) begin
      refPixel(k, eb, ee);
      checks++;
      if ((obsPix[k] !== 3'(k)) || (obsEmpty[k] !== ee)) begin
        errors++; $display("[TB] FAIL fh_result[%0d]: got pix %0d empty %b expected pix %0d empty %b", k, obsPix[k], obsEmpty[k], k, ee);
      end
      if (!ee) begin
        checks++;
        if (obsBin[k] !== eb) begin
          errors++; $display("[TB] FAIL fh_result_bin[%0d]: got %0d expected %0d", k, obsBin[k], eb);
        end
      end
    end
    checks++;
    if ((obsHisBad !== 0) || (obsHisAfter !== 1'b0)) begin
      errors++; $display("[TB] FAIL fh_his_num: got %0d bad cycles and final %b expected 0 and 0", obsHisBad, obsHisAfter);
    end
  endtask

  task automatic test_ignored_start();
    logic [NB-1:0] eb;
    logic          ee;
    fillRandom(-1);
    applyStimulus(RUN_CYC, 1'b1, 1'b0);
    checks++;
    if ((obsN !== PIXELS) || (obsDoneN !== 1)) begin
      errors++; $display("[TB] FAIL ign_counts: got %0d results %0d done expected %0d and 1", obsN, obsDoneN, PIXELS);
    end
    checks++;
    if ((obsBusyFall !== DONE_CYC+1) || (obsBusyBad !== 0)) begin
      errors++; $display("[TB] FAIL ign_busy: fall at %0d with %0d bad cycles expected fall at %0d", obsBusyFall, obsBusyBad, DONE_CYC+1);
    end
    for (int k = 0; k < PIXELS; k++) begin
      refPixel(k, eb, ee);
      checks++;
      if ((obsCyc[k] !== PERIOD*(k+1)) || (obsBin[k] !== eb) || (obsEmpty[k] !== ee)) begin
        errors++; $display("[TB] FAIL ign_result[%0d]: got cyc %0d bin %0d empty %b expected cyc %0d bin %0d empty %b",
                           k, obsCyc[k], obsBin[k], obsEmpty[k], PERIOD*(k+1), eb, ee);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [NB-1:0] eb;
    logic          ee;
    fillRandom(-1);
    applyStimulus(200, 1'b0, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (allOuts !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %h expected 0", allOuts);
    end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (allOuts !== '0) begin
        errors++; $display("[TB] FAIL midreset_quiet cycle %0d: got %h expected 0", c, allOuts);
      end
    end
    fillRandom($urandom_range(0, PIXELS-1));
    applyStimulus(RUN_CYC, 1'b0, 1'b0);
    checks++;
    if ((obsN !== PIXELS) || (obsDoneCyc !== DONE_CYC)) begin
      errors++; $display("[TB] FAIL post_reset_pass: got %0d results done at %0d expected %0d at %0d", obsN, obsDoneCyc, PIXELS, DONE_CYC);
    end
    for (int k = 0; k < PIXELS; k++) begin
      refPixel(k, eb, ee);
      checks++;
      if ((obsPix[k] !== 3'(k)) || (obsEmpty[k] !== ee) || (!ee && (obsBin[k] !== eb))) begin
        errors++; $display("[TB] FAIL post_reset_result[%0d]: got pix %0d bin %0d empty %b expected pix %0d bin %0d empty %b",
                           k, obsPix[k], obsBin[k], obsEmpty[k], k, eb, ee);
      end
    end
    checks++;
    if ((obsHisBad !== 0) || (obsHisAfter !== 1'b1)) begin
      errors++; $display("[TB] FAIL post_reset_his_num: got %0d bad cycles and final %b expected 0 and 1", obsHisBad, obsHisAfter);
    end
  endtask

  initial begin
    reset = 1'b0;
    acq   = 1'b0;
    test_reset();
    test_ch_pass();
    test_alternation_zero_pixel();
    test_ignored_start();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
